// File: rtl/imem_arb_pkg.sv
// Shared types and default sizes for the instruction-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_arb_pkg;

  // Owner tag carried through the in-flight read FIFO.
  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_MEM   = 1'b1
  } req_src_e;

  localparam int DEF_MEM_ADDR_WIDTH  = 30;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_MAX_OUTSTANDING = 2;
  localparam int DEF_MAX_WAIT        = 4;

endpackage

// File: rtl/imem_arbiter_tag_fifo.sv
// Synchronous 1-bit tag FIFO remembering which requester owns each in-flight read.
// Latency: pushed entry is visible at pop_dat_o on the cycle after the push.
// Backpressure: push is ignored when full and pop is ignored when empty; the caller gates on full_o/empty_o.
// Ports: clk, rst_n, push_i/push_dat_i (write side), pop_i/pop_dat_o (read side), full_o, empty_o.
module tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic push_dat_i,
  input  logic pop_i,
  output logic pop_dat_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [DEPTH-1:0] mem_q,    mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             do_push,  do_pop;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat_i;
      // Explicit wrap keeps the pointer legal for any depth, including 1.
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction SRAM between fetch and the memory/loader requester; routes responses by tag.
// Latency: grants and SRAM issue are combinational in the request cycle; responses pass through with 0 added cycles.
// Backpressure: read grants stall while the tag FIFO is full or the read collides with a same-cycle write.
// Ports: f_* fetch read side, m_rd_*/m_rsp_* memory read side, m_wr_* memory write side,
//        sram_* SimRAM ports, err_rsp sticky flag for a response with nothing outstanding.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH  = DEF_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int MAX_WAIT        = DEF_MAX_WAIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      f_req,
  input  logic [MEM_ADDR_WIDTH-1:0] f_addr,
  output logic                      f_gnt,
  output logic                      f_rsp_valid,
  output logic [DATA_WIDTH-1:0]     f_rsp_data,
  input  logic                      m_rd_req,
  input  logic [MEM_ADDR_WIDTH-1:0] m_rd_addr,
  output logic                      m_rd_gnt,
  output logic                      m_rsp_valid,
  output logic [DATA_WIDTH-1:0]     m_rsp_data,
  input  logic                      m_wr_req,
  input  logic [MEM_ADDR_WIDTH-1:0] m_wr_addr,
  input  logic [DATA_WIDTH-1:0]     m_wr_data,
  output logic                      m_wr_gnt,
  output logic                      sram_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic                      sram_rd_valid,
  input  logic [DATA_WIDTH-1:0]     sram_rd_data,
  output logic                      sram_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [DATA_WIDTH-1:0]     sram_wr_data,
  output logic                      err_rsp
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

  logic [WW-1:0] wait_q, wait_d;
  logic          age_q,  age_d;
  logic          err_q,  err_d;

  logic     fifo_full, fifo_empty, pop_dat;
  logic     wr_gnt, f_hit, m_hit, f_ok, m_ok, m_win, rsp_fire;
  req_src_e push_src, pop_src;

  // Writes are always accepted; everything is gated by rst_n so outputs read 0 during reset.
  assign wr_gnt = rst_n & m_wr_req;

  // A read to the address being written this cycle waits one cycle so it sees the new data.
  assign f_hit = wr_gnt & (f_addr    == m_wr_addr);
  assign m_hit = wr_gnt & (m_rd_addr == m_wr_addr);

  // Full is the registered occupancy: a same-cycle pop never frees a slot for a grant.
  assign f_ok = rst_n & f_req    & ~f_hit & ~fifo_full;
  assign m_ok = rst_n & m_rd_req & ~m_hit & ~fifo_full;

  // Fetch wins by default; an aged memory read takes priority. A blocked winner yields to the other.
  assign m_win    = m_ok & (age_q | ~f_ok);
  assign m_rd_gnt = m_win;
  assign f_gnt    = f_ok & ~m_win;

  assign sram_rd_en   = f_gnt | m_rd_gnt;
  assign sram_rd_addr = m_rd_gnt ? m_rd_addr : (f_gnt ? f_addr : '0);

  assign m_wr_gnt     = wr_gnt;
  assign sram_wr_en   = wr_gnt;
  assign sram_wr_addr = wr_gnt ? m_wr_addr : '0;
  assign sram_wr_data = wr_gnt ? m_wr_data : '0;

  assign push_src = m_rd_gnt ? SRC_MEM : SRC_FETCH;

  tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (sram_rd_en),
    .push_dat_i (push_src),
    .pop_i      (sram_rd_valid),
    .pop_dat_o  (pop_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign pop_src  = req_src_e'(pop_dat);
  // A response with no outstanding tag is dropped rather than routed.
  assign rsp_fire = rst_n & sram_rd_valid & ~fifo_empty;

  assign f_rsp_valid = rsp_fire & (pop_src == SRC_FETCH);
  assign m_rsp_valid = rsp_fire & (pop_src == SRC_MEM);
  assign f_rsp_data  = f_rsp_valid ? sram_rd_data : '0;
  assign m_rsp_data  = m_rsp_valid ? sram_rd_data : '0;

  assign err_rsp = err_q;

  always_comb begin
    wait_d = wait_q;
    age_d  = age_q;
    err_d  = err_q | (sram_rd_valid & fifo_empty);
    if (m_rd_gnt) begin
      wait_d = '0;
      age_d  = 1'b0;
    end else begin
      if (m_rd_req && (wait_q != WAIT_SAT)) begin
        wait_d = wait_q + 1'b1;
      end
      if (wait_d == WAIT_SAT) begin
        age_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      age_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      age_q  <= age_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural SimRAM and a per-port response scoreboard.
// Latency: SimRAM latency is programmable per issued read, responses kept in order.
// Backpressure: requests are held until granted.
module tb_imem_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt, f_rsp_valid;
  logic [DW-1:0] f_rsp_data;
  logic          m_rd_req;
  logic [AW-1:0] m_rd_addr;
  logic          m_rd_gnt, m_rsp_valid;
  logic [DW-1:0] m_rsp_data;
  logic          m_wr_req;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;
  logic          m_wr_gnt;
  logic          sram_rd_en;
  logic [AW-1:0] sram_rd_addr;
  logic          sram_rd_valid;
  logic [DW-1:0] sram_rd_data;
  logic          sram_wr_en;
  logic [AW-1:0] sram_wr_addr;
  logic [DW-1:0] sram_wr_data;
  logic          err_rsp;

  imem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_gnt(m_rd_gnt),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_gnt(m_wr_gnt),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_valid(sram_rd_valid), .sram_rd_data(sram_rd_data),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .err_rsp(err_rsp)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Behavioural SimRAM: 256 words, in-order responses.
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic [DW-1:0] mem [256];
  rsp_t          rq[$];
  logic [DW-1:0] exp_f[$];
  logic [DW-1:0] exp_m[$];
  int            cyc      = 0;
  int            last_due = 0;
  int            lat      = 1;
  logic          inj      = 1'b0;

  // Outputs sampled mid-cycle.
  logic          s_f_gnt, s_m_gnt, s_wr_gnt, s_rd_en, s_wr_en, s_err;
  logic          s_f_rsp_v, s_m_rsp_v;
  logic [DW-1:0] s_f_rsp_d, s_m_rsp_d, s_wr_data;
  logic [AW-1:0] s_rd_addr, s_wr_addr;

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    rsp_t r;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      sram_rd_valid = 1'b1;
      sram_rd_data  = rq[0].data;
    end else if (inj) begin
      sram_rd_valid = 1'b1;
      sram_rd_data  = 32'hBAD0_BAD0;
    end else begin
      sram_rd_valid = 1'b0;
      sram_rd_data  = '0;
    end
    #2;
    s_f_gnt = f_gnt;   s_m_gnt = m_rd_gnt;   s_wr_gnt = m_wr_gnt;
    s_rd_en = sram_rd_en; s_rd_addr = sram_rd_addr;
    s_wr_en = sram_wr_en; s_wr_addr = sram_wr_addr; s_wr_data = sram_wr_data;
    s_f_rsp_v = f_rsp_valid; s_f_rsp_d = f_rsp_data;
    s_m_rsp_v = m_rsp_valid; s_m_rsp_d = m_rsp_data;
    s_err = err_rsp;
    if (sram_rd_valid && !inj) void'(rq.pop_front());

    // Response scoreboard: each port sees its own data in issue order.
    if (s_f_rsp_v | s_m_rsp_v) chk("rsp_onehot", s_f_rsp_v & s_m_rsp_v, 0);
    if (s_f_rsp_v) begin
      if (exp_f.size() == 0) chk("f_rsp_unexpected", s_f_rsp_v, 0);
      else                   chk("f_rsp_data", s_f_rsp_d, exp_f.pop_front());
    end
    if (s_m_rsp_v) begin
      if (exp_m.size() == 0) chk("m_rsp_unexpected", s_m_rsp_v, 0);
      else                   chk("m_rsp_data", s_m_rsp_d, exp_m.pop_front());
    end

    // Grant bookkeeping: expected data is what the model memory holds at issue.
    if (s_f_gnt | s_m_gnt) begin
      chk("one_rd_gnt", s_f_gnt & s_m_gnt, 0);
      chk("rd_en", s_rd_en, 1);
      chk("rd_addr", s_rd_addr, s_m_gnt ? m_rd_addr : f_addr);
      if (s_m_gnt) exp_m.push_back(mem[m_rd_addr[7:0]]);
      else         exp_f.push_back(mem[f_addr[7:0]]);
    end

    if (s_rd_en) begin
      r.data = mem[s_rd_addr[7:0]];
      r.due  = cyc + lat;
      if (rq.size() > 0 && r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      rq.push_back(r);
    end
    if (s_wr_en) mem[s_wr_addr[7:0]] = s_wr_data;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; m_rd_req = 1'b0; m_wr_req = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 12 && rq.size() > 0; i++) cycle();
    cycle();
    chk("drain_left", rq.size() + exp_f.size() + exp_m.size(), 0);
  endtask

  typedef struct {
    logic          f_req;
    logic [7:0]    f_addr;
    logic          m_req;
    logic [7:0]    m_addr;
    logic          w_req;
    logic [7:0]    w_addr;
    logic [DW-1:0] w_data;
    logic          e_fg;
    logic          e_mg;
    logic [7:0]    e_rd_addr;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [5:0] c_pat;
    int         fk;

    vt[0] = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0, 8'h05};
    vt[1] = '{1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 8'h07};
    vt[2] = '{1'b1, 8'h03, 1'b1, 8'h09, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0, 8'h03};
    vt[3] = '{1'b0, 8'h00, 1'b1, 8'h09, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 8'h09};
    vt[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h20, 32'h1111_2222, 1'b0, 1'b0, 8'h00};
    vt[5] = '{1'b1, 8'h20, 1'b1, 8'h21, 1'b1, 8'h20, 32'h3333_4444, 1'b0, 1'b1, 8'h21};
    vt[6] = '{1'b1, 8'h30, 1'b1, 8'h22, 1'b1, 8'h22, 32'h5555_6666, 1'b1, 1'b0, 8'h30};
    vt[7] = '{1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 8'h40, 32'h7777_8888, 1'b1, 1'b0, 8'h41};
    vt[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00};
    vt[9] = '{1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 8'h11};

    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;

    // Reset state: everything 0 even with requests and a response presented.
    rst_n = 1'b0;
    f_req = 1'b1; f_addr = 30'h10; m_rd_req = 1'b1; m_rd_addr = 30'h11;
    m_wr_req = 1'b1; m_wr_addr = 30'h12; m_wr_data = 32'hFFFF_FFFF;
    sram_rd_valid = 1'b1; sram_rd_data = 32'h1234_5678;
    #2;
    chk("reset_outputs",
        {f_gnt, m_rd_gnt, m_wr_gnt, sram_rd_en, sram_wr_en, f_rsp_valid, m_rsp_valid, err_rsp}, 0);
    chk("reset_buses", {sram_rd_addr, sram_wr_addr, sram_wr_data, f_rsp_data, m_rsp_data}, 0);
    idle_inputs();
    sram_rd_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch stream 0x10..0x13 with latency 1.
    lat = 1;
    for (int k = 0; k < 5; k++) begin
      f_req = (k < 4); f_addr = 30'h10 + 30'(k);
      cycle();
      if (k < 4) chk("A_f_gnt", s_f_gnt, 1);
      if (k > 0) begin
        chk("A_f_rsp_valid", s_f_rsp_v, 1);
        chk("A_f_rsp_data", s_f_rsp_d, 32'hA000_0010 + 32'(k - 1));
        chk("A_m_rsp_valid", s_m_rsp_v, 0);
      end
    end
    drain();

    // Single-cycle arbitration vectors, one idle cycle between each.
    for (int i = 0; i < 10; i++) begin
      f_req = vt[i].f_req;    f_addr = 30'(vt[i].f_addr);
      m_rd_req = vt[i].m_req; m_rd_addr = 30'(vt[i].m_addr);
      m_wr_req = vt[i].w_req; m_wr_addr = 30'(vt[i].w_addr); m_wr_data = vt[i].w_data;
      cycle();
      chk($sformatf("V%0d_f_gnt", i), s_f_gnt, vt[i].e_fg);
      chk($sformatf("V%0d_m_gnt", i), s_m_gnt, vt[i].e_mg);
      chk($sformatf("V%0d_rd_en", i), s_rd_en, vt[i].e_fg | vt[i].e_mg);
      chk($sformatf("V%0d_rd_addr", i), s_rd_addr, 30'(vt[i].e_rd_addr));
      chk($sformatf("V%0d_wr_gnt", i), {s_wr_gnt, s_wr_en}, {2{vt[i].w_req}});
      if (vt[i].w_req) chk($sformatf("V%0d_wr_bus", i), {s_wr_addr, s_wr_data},
                           {30'(vt[i].w_addr), vt[i].w_data});
      idle_inputs();
      cycle();
    end
    drain();

    // Aging: both held; memory wins every fifth cycle.
    f_req = 1'b1; f_addr = 30'h50; m_rd_req = 1'b1; m_rd_addr = 30'h60;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk($sformatf("B%0d_m_gnt", k), s_m_gnt, (k == 4 || k == 9));
      chk($sformatf("B%0d_f_gnt", k), s_f_gnt, !(k == 4 || k == 9));
    end
    drain();

    // Latency 3: FIFO fills after two grants; a pop frees a slot only the cycle after.
    lat = 3; c_pat = 6'b110011;
    f_req = 1'b1; f_addr = 30'h30;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk($sformatf("C%0d_f_gnt", k), s_f_gnt, c_pat[5-k]);
    end
    drain();
    lat = 1;

    // Write/read collision on 0x20.
    f_req = 1'b1; f_addr = 30'h20;
    m_wr_req = 1'b1; m_wr_addr = 30'h20; m_wr_data = 32'hDEAD_BEEF;
    cycle();
    chk("D_wr_gnt", s_wr_gnt, 1);
    chk("D_f_gnt_blocked", s_f_gnt, 0);
    chk("D_wr_data", s_wr_data, 32'hDEAD_BEEF);
    m_wr_req = 1'b0;
    cycle();
    chk("D_f_gnt_retry", s_f_gnt, 1);
    f_req = 1'b0;
    cycle();
    chk("D_rsp_valid", s_f_rsp_v, 1);
    chk("D_rsp_data", s_f_rsp_d, 32'hDEAD_BEEF);
    drain();

    // Interleaved traffic, mixed latency, occasional writes.
    fk = 0;
    for (int k = 0; k < 60; k++) begin
      if (!f_req)    begin f_req = 1'($urandom_range(0, 1)); f_addr = 30'($urandom_range(0, 255)); end
      if (!m_rd_req) begin m_rd_req = 1'($urandom_range(0, 1)); m_rd_addr = 30'($urandom_range(0, 255)); end
      m_wr_req  = ($urandom_range(0, 3) == 0);
      m_wr_addr = 30'($urandom_range(0, 255));
      m_wr_data = $urandom;
      lat = $urandom_range(1, 3);
      cycle();
      if (s_f_gnt) begin f_req = 1'b0; fk++; end
      if (s_m_gnt) m_rd_req = 1'b0;
    end
    drain();
    chk("E_some_fetches", (fk > 5), 1);
    lat = 1;

    // Spurious response sets a sticky error.
    chk("F_err_idle", s_err, 0);
    inj = 1'b1;
    cycle();
    inj = 1'b0;
    chk("F_spur_no_rsp", {s_f_rsp_v, s_m_rsp_v}, 0);
    cycle(); cycle();
    chk("F_err_sticky", s_err, 1);

    // Reset in the middle of traffic.
    lat = 3; f_req = 1'b1; f_addr = 30'h70;
    cycle(); cycle();
    #1 rst_n = 1'b0;
    #1;
    chk("G_rst_outputs", {f_gnt, m_rd_gnt, sram_rd_en, f_rsp_valid, m_rsp_valid, err_rsp}, 0);
    idle_inputs();
    rq.delete(); exp_f.delete(); exp_m.delete(); last_due = 0;
    sram_rd_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // Stale tags would leave the FIFO full; expect two grants then a stall.
    f_req = 1'b1; f_addr = 30'h71;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("G%0d_f_gnt", k), s_f_gnt, (k < 2));
    end
    drain();
    chk("G_err_clear", s_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-read/single-write instruction SimRAM between two requesters: the fetch unit (NextIP output) and a memory/loader requester (data loads, program loading, debug).
- Arbitrates the read port with aged fixed priority and grants the write port to the memory requester.
- Tracks outstanding reads in order so each SRAM response returns to the requester that issued it.
- Sits between NextIP/LSU and SimRAM inside MigUCore.

Parameters:
- MEM_ADDR_WIDTH, 30, word-address width (ADDR_WIDTH minus 2).
- DATA_WIDTH, 32, SRAM word width.
- MAX_OUTSTANDING, 2, depth of the in-flight read tag FIFO (power of 2, at least 1).
- MAX_WAIT, 4, cycles a stalled memory read waits before it takes priority over fetch (at least 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- f_req  in  1  fetch read request; held until granted
- f_addr  in  MEM_ADDR_WIDTH  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rsp_valid  out  1  fetch read data valid
- f_rsp_data  out  DATA_WIDTH  fetch read data
- m_rd_req  in  1  memory read request; held until granted
- m_rd_addr  in  MEM_ADDR_WIDTH  memory read word address
- m_rd_gnt  out  1  memory read accepted
- m_rsp_valid  out  1  memory read data valid
- m_rsp_data  out  DATA_WIDTH  memory read data
- m_wr_req  in  1  memory write request
- m_wr_addr  in  MEM_ADDR_WIDTH  write word address
- m_wr_data  in  DATA_WIDTH  write data
- m_wr_gnt  out  1  write accepted
- sram_rd_en  out  1  to SimRAM rd_en
- sram_rd_addr  out  MEM_ADDR_WIDTH  to SimRAM rd_addr
- sram_rd_valid  in  1  from SimRAM rd_valid
- sram_rd_data  in  DATA_WIDTH  from SimRAM rd_data
- sram_wr_en  out  1  to SimRAM wr_en
- sram_wr_addr  out  MEM_ADDR_WIDTH  to SimRAM wr_addr
- sram_wr_data  out  DATA_WIDTH  to SimRAM wr_data
- err_rsp  out  1  sticky: SRAM response arrived with no read outstanding

Behaviour:
- Reset (rst_n low, asynchronous): tag FIFO empty, wait counter 0, age flag 0, err_rsp 0.
- During reset all outputs are 0; grants are gated by rst_n.
- Grants are combinational in the request cycle. A request is consumed when req and gnt are both 1. The SRAM transaction issues in the same cycle: sram_rd_en equals f_gnt OR m_rd_gnt, and sram_rd_addr comes from the winner.
- SimRAM contract: exactly one sram_rd_valid per sram_rd_en, in order, latency 1 or more.
- Read grant is blocked while the tag FIFO is full. A pop in the same cycle does not free a slot (no combinational pop-to-grant path).
- Priority: fetch wins by default; memory wins when the age flag is 1. At most one read grant per cycle.
- Wait counter: increments each cycle m_rd_req is 1 and m_rd_gnt is 0, saturating at MAX_WAIT. The age flag sets when the counter reaches MAX_WAIT. Counter and flag both clear on m_rd_gnt.
- Write: m_wr_gnt = m_wr_req. sram_wr_* is driven directly from m_wr_* when granted; write data and address pass straight through.
- Read/write address collision: if a write is granted in a cycle, any read to the same address is not granted that cycle. The read retries the next cycle, so it observes the written data.
- Tag FIFO: push on each read grant with 0 = fetch, 1 = mem; pop on sram_rd_valid. The popped tag routes sram_rd_data to f_rsp_* or m_rsp_*. Response outputs are combinational from the SRAM (0 added latency); the non-selected valid is 0.
- Simultaneous push and pop is legal at any occupancy below full. The count is unchanged and pointers wrap modulo MAX_OUTSTANDING.
- sram_rd_valid with an empty FIFO: data is dropped, err_rsp sets and holds until reset.
- Reset mid-operation flushes tags. Any in-flight SRAM responses are the integrator's responsibility and flag err_rsp.

Decomposition:
- Package imem_arb_pkg holds typedef req_src_e {SRC_FETCH=0, SRC_MEM=1} and default-width constants.
- One sub-module: tag_fifo (synchronous FIFO, 1-bit payload, depth MAX_OUTSTANDING, full/empty outputs, async active-low reset).

Test Plan:
- Fetch only, f_req held 4 cycles with latency-1 SRAM → f_gnt on 4 consecutive cycles; f_rsp_valid on 4 cycles, each delayed by 1, with data at addresses 0x10..0x13.
- f_req and m_rd_req held together → fetch granted for cycles 0-3; m_rd_gnt in cycle 4 (MAX_WAIT=4); fetch resumes in cycle 5; wait counter back to 0.
- SRAM latency forced to 3, f_req held → exactly 2 grants, then f_gnt stays 0 until the first response pops.
- m_wr_req to 0x20 with data 0xDEADBEEF in the same cycle as f_req to 0x20 → write granted, f_gnt 0; next cycle f_gnt 1 and the response returns 0xDEADBEEF.
- Interleaved fetch and mem reads with mixed latency → every response appears on the owner's port in issue order; the other port's valid stays 0.
- Spurious sram_rd_valid with no reads outstanding → err_rsp goes 1 and stays 1; rst_n pulsed low mid-traffic → all outputs 0 immediately, err_rsp 0, FIFO empty.
